registrador_estagio_skid: RTL and testbench
===========================================

# registrador_estagio_skid

Parametrised pipeline-stage register, the next generation of the fixed-field EX/MEM stage register. It carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake, with a 2-entry skid buffer so upstream `in_ready` depends only on registered state. It adds a synchronous flush for branch/jump squash and a saturating stall counter. One instance replaces each hand-written inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB), with the control and data fields packed into the payload.

## Interface
- `DATA_W`, 32: payload width in bits (control + data fields packed by the instantiator), ≥1
- `CNT_W`, 16: stall counter width, ≥1
- `FLUSH_ZERO`, 1: 1 = flush clears the payload registers to 0; 0 = flush clears only occupancy
- `clock`  in  1  sole clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high; one clock in reset suffices
- `flush`  in  1  synchronous squash of stage contents (was `ctrlDesvio`)
- `in_valid`  in  1  upstream has payload
- `in_data`  in  DATA_W  upstream payload
- `in_ready`  out  1  stage can accept; equals (state != FULL)
- `out_valid`  out  1  stage holds payload; equals (state != EMPTY)
- `out_data`  out  DATA_W  head payload (main register)
- `out_ready`  in  1  downstream accepts
- `stall_count`  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: `main` (head, drives out_data) and `skid` (second entry); state EMPTY / ONE / FULL.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- EMPTY: in_fire → main ← in_data, go ONE. out_ready ignored.
- ONE: in_fire & out_fire → main ← in_data, stay ONE. in_fire only → skid ← in_data, go FULL. out_fire only → go EMPTY; main keeps its value. Neither → hold.
- FULL: in_ready=0, in_data ignored. out_fire → main ← skid, go ONE. Otherwise hold.
- Order preserved: payloads leave in acceptance order; none duplicated or dropped except by flush.
- Flush (flush=1, reset=0): state ← EMPTY; if FLUSH_ZERO=1, main and skid ← 0. Any in_fire in the flush cycle is consumed by the handshake and discarded. Any out_fire in that cycle completes normally, since out_data was valid at the edge.
- Priority: reset > flush > handshake.
- stall_count: +1 on each edge where out_valid=1 & out_ready=0. Holds at 2^CNT_W−1. Cleared only by reset; flush does not clear it.
- Reset: state EMPTY, main=0, skid=0, stall_count=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0.
- out_data is undefined-by-contract while out_valid=0. It still holds main's value (0 after reset, or after flush with FLUSH_ZERO=1).

## Timing
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. available in cycle N+1.
- Throughput: 1 payload/cycle while out_ready=1.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from out_ready or in_valid to any output.
- Stall absorption: after out_ready drops, at most one more in_fire is accepted (into skid). in_ready falls the cycle after that fire.
- Recovery: in the cycle after the first out_fire from FULL, in_ready=1.
- Flush takes effect at the edge it is sampled: the next cycle shows out_valid=0 and in_ready=1.
- Reset mid-operation: same as reset from idle, and stall_count is lost.
- Simultaneous flush + in_valid in FULL: in_ready=0, so there is no fire; after the edge the state is EMPTY.

## Test plan
- Reset: hold reset 1 cycle with in_valid=1, in_data=0xDEADBEEF → after release, out_valid=0, in_ready=1, out_data=0, stall_count=0.
- Streaming: out_ready=1, send 0x1,0x2,0x3 on consecutive cycles → out_data shows 0x1,0x2,0x3 in cycles 1,2,3 with out_valid=1; in_ready stays 1 throughout.
- Backpressure and skid: send 0xA then 0xB, with out_ready=0 from cycle 1 → state FULL, in_ready=0, out_data=0xA. Raise out_ready for 2 cycles → 0xA then 0xB delivered, no loss. stall_count equals the number of cycles out_ready was held low with out_valid=1.
- Flush: in FULL holding 0x5,0x6, assert flush 1 cycle with FLUSH_ZERO=1 → next cycle out_valid=0, out_data=0, in_ready=1; stall_count unchanged. Repeat with FLUSH_ZERO=0 → out_data=0x5 with out_valid=0.
- Flush + fire: state ONE with 0x7, out_ready=1, in_valid=1 with 0x8, flush=1 → 0x7 delivered, 0x8 discarded, state EMPTY.
- Saturation: CNT_W=3, hold out_valid=1, out_ready=0 for 10 cycles → stall_count stops at 7; reset clears it to 0.

Source files
------------

// File: rtl/registrador_estagio_skid.sv
// Parametrised pipeline-stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module registrador_estagio_skid #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 16,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] main_q, main_next;
    logic [DATA_W-1:0] skid_q, skid_next;
    logic              in_fire;
    logic              out_fire;

    // Handshake outputs decode registered state only, so upstream never sees out_ready combinationally.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
            if (FLUSH_ZERO) begin
                main_next = '0;
                skid_next = '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_next  = in_data;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire) begin
                        skid_next  = in_data;
                        state_next = FULL;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_next  = skid_q;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: payload registers are reset as well, because out_data must read 0 right after reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    // Saturates at all-ones; only reset clears it, flush leaves it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_registrador_estagio_skid.sv
// Self-checking bench: three instances (default, FLUSH_ZERO=0, CNT_W=3) share one stimulus
// and are compared every cycle against a queue-based reference model.
module tb_registrador_estagio_skid;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [31:0] od_a, od_b, od_c;
    logic [15:0] sc_a, sc_b;
    logic [2:0]  sc_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted payloads in order, plus the value out_data holds while empty.
    logic [31:0] q[$];
    logic [31:0] hold_z, hold_k;
    int unsigned st_a, st_c;

    always #5 clock = ~clock;

    registrador_estagio_skid u_dut_a (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready), .stall_count(sc_a)
    );

    registrador_estagio_skid #(.FLUSH_ZERO(1'b0)) u_dut_b (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready), .stall_count(sc_b)
    );

    registrador_estagio_skid #(.CNT_W(3)) u_dut_c (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_c), .out_valid(ov_c), .out_data(od_c), .out_ready(out_ready), .stall_count(sc_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit inf, outf;
        if (reset) begin
            q.delete();
            hold_z = '0;
            hold_k = '0;
            st_a   = 0;
            st_c   = 0;
            return;
        end
        if (q.size() > 0 && !out_ready) begin
            if (st_a < 65535) st_a++;
            if (st_c < 7) st_c++;
        end
        if (q.size() > 0) begin
            hold_z = q[0];
            hold_k = q[0];
        end
        if (flush) begin
            q.delete();
            hold_z = '0;
        end else begin
            inf  = in_valid && (q.size() < 2);
            outf = (q.size() > 0) && out_ready;
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(in_data);
        end
        if (q.size() > 0) begin
            hold_z = q[0];
            hold_k = q[0];
        end
    endtask

    task automatic check_all();
        logic        e_ir, e_ov;
        logic [31:0] e_z, e_k;
        e_ir = (q.size() < 2);
        e_ov = (q.size() > 0);
        e_z  = e_ov ? q[0] : hold_z;
        e_k  = e_ov ? q[0] : hold_k;
        check("a_in_ready", ir_a, e_ir);
        check("a_out_valid", ov_a, e_ov);
        check("a_out_data", od_a, e_z);
        check("a_stall_count", sc_a, st_a);
        check("b_in_ready", ir_b, e_ir);
        check("b_out_valid", ov_b, e_ov);
        check("b_out_data", od_b, e_k);
        check("b_stall_count", sc_b, st_a);
        check("c_in_ready", ir_c, e_ir);
        check("c_out_valid", ov_c, e_ov);
        check("c_out_data", od_c, e_z);
        check("c_stall_count", sc_c, st_c);
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic ordy);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset with a pending upstream payload.
        step(1, 0, 1, 32'hDEADBEEF, 0);
        check("rst_out_valid", ov_a, 1'b0);
        check("rst_in_ready", ir_a, 1'b1);
        check("rst_out_data", od_a, 32'h0);
        check("rst_stall", sc_a, 32'h0);

        // Streaming at full throughput.
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 1, 32'(k), 1);
            check("stream_data", od_a, 32'(k));
            check("stream_valid", ov_a, 1'b1);
            check("stream_ready", ir_a, 1'b1);
        end
        step(0, 0, 0, '0, 1);
        check("stream_drain", ov_a, 1'b0);

        // Backpressure into the skid entry, then recovery.
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        check("bp_in_ready", ir_a, 1'b0);
        check("bp_head", od_a, 32'hA);
        step(0, 0, 1, 32'hC, 0);
        check("bp_hold_head", od_a, 32'hA);
        step(0, 0, 0, '0, 1);
        check("bp_second", od_a, 32'hB);
        check("bp_recover", ir_a, 1'b1);
        step(0, 0, 0, '0, 1);
        check("bp_empty", ov_a, 1'b0);
        check("bp_stall", sc_a, 32'd2);

        // Flush from FULL (out_ready high so the stall count stays put).
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 32'h5, 0);
        step(0, 0, 1, 32'h6, 0);
        step(0, 1, 0, '0, 1);
        check("fl_valid", ov_a, 1'b0);
        check("fl_zero_data", od_a, 32'h0);
        check("fl_ready", ir_a, 1'b1);
        check("fl_stall_kept", sc_a, 32'd1);
        check("fl_nozero_data", od_b, 32'h5);

        // Flush concurrent with in_fire and out_fire.
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 32'h7, 0);
        check("ff_head", od_a, 32'h7);
        step(0, 1, 1, 32'h8, 1);
        check("ff_empty", ov_a, 1'b0);
        step(0, 0, 0, '0, 1);
        check("ff_discard", ov_a, 1'b0);

        // Flush with in_valid while FULL.
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h12, 0);
        step(0, 1, 1, 32'h13, 0);
        check("ffull_empty", ov_a, 1'b0);

        // Stall counter saturation on the 3-bit instance.
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 32'h9, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, '0, 0);
        check("sat_c", sc_c, 32'd7);
        check("sat_a", sc_a, 32'd10);
        step(1, 0, 0, '0, 0);
        check("sat_reset", sc_c, 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom,
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
